// File: rtl/cpu_control.sv
// cpu_control: instruction register, decoder and control FSM for a simple
// 16-bit datapath. Latches an instruction in WAIT and, on start, sequences
// register reads, the ALU step, status load and writeback.
// Optional feature: define CPU_CTRL_ILLEGAL_EN to add the `illegal` output.
module cpu_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        asel,
    output logic        bsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
`ifdef CPU_CTRL_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WREG,
        S_CMPS
    } state_t;

    state_t      state, state_next;
    logic [15:0] ir;

    // IR field aliases
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    // Instruction class decode
    logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn, is_illegal;
    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_add     = (opcode == 3'b101) && (op == 2'b00);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    assign is_and     = (opcode == 3'b101) && (op == 2'b10);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_illegal = !(is_mov_imm || is_mov_reg || is_add || is_cmp || is_and || is_mvn);

    // Immediate and ALU fields come straight from IR in every state
    assign shift  = ir[4:3];
    assign ALUop  = op;
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    // Instruction register: only accepts a new word while idle
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            ir <= '0;
        else if (state == S_WAIT && load)
            ir <= in;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_WAIT;
        else
            state <= state_next;
    end

    // Next-state and per-state control outputs; strobes are gated off during reset
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        w          = 1'b0;
        writenum   = 3'd0;
        readnum    = 3'd0;
        write      = 1'b0;
        vsel       = 2'b00;
        asel       = 1'b0;
        bsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)
                    state_next = S_WIMM;
                else if (is_add || is_and || is_cmp)
                    state_next = S_GETA;
                else if (is_mov_reg || is_mvn)
                    state_next = S_GETB;
                else
                    state_next = S_WAIT;
            end
            S_WIMM: begin
                vsel       = 2'b10;
                writenum   = rn;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_GETA: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = S_GETB;
            end
            S_GETB: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = is_cmp ? S_CMPS : S_EXEC;
            end
            S_EXEC: begin
                // MOV reg forces A to zero so the ALU add yields sh(Rm)
                asel       = is_mov_reg;
                loadc      = 1'b1;
                state_next = S_WREG;
            end
            S_WREG: begin
                vsel       = 2'b00;
                writenum   = rd;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_CMPS: begin
                loads      = 1'b1;
                state_next = S_WAIT;
            end
            default: state_next = S_WAIT;
        endcase

        if (reset) begin
            write = 1'b0;
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
        end
    end

`ifdef CPU_CTRL_ILLEGAL_EN
    // Flags the DECODE cycle of an unsupported opcode/op pair
    assign illegal = (state == S_DECODE) && is_illegal;
`endif

endmodule
